// File: rtl/cdb_reservation_station.sv
// Four-slot reservation station snooping the 16-bit CDB: holds issued ops until
// both operands are known, dispatches them in slot order, frees slots on completion.
module cdb_reservation_station (
    input  logic        clock,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic [1:0]  issue_op,
    input  logic [2:0]  issue_dest,
    input  logic [9:0]  issue_vj,
    input  logic [2:0]  issue_qj,
    input  logic [9:0]  issue_vk,
    input  logic [2:0]  issue_qk,
    output logic        issue_ready,
    output logic [1:0]  issue_slot,
    input  logic [15:0] cdb,
    input  logic        disp_ready,
    output logic        disp_valid,
    output logic [1:0]  disp_op,
    output logic [9:0]  disp_vj,
    output logic [9:0]  disp_vk,
    output logic [1:0]  disp_slot,
    output logic [2:0]  disp_dest,
    output logic [3:0]  rs_busy
);

    localparam int NUM_SLOTS = 4;

    typedef enum logic [1:0] {
        SLOT_FREE = 2'd0,
        SLOT_WAIT = 2'd1,
        SLOT_EXEC = 2'd2
    } slot_state_t;

    slot_state_t state_reg [NUM_SLOTS];
    slot_state_t state_next [NUM_SLOTS];
    logic [1:0]  op_reg    [NUM_SLOTS];
    logic [1:0]  op_next   [NUM_SLOTS];
    logic [2:0]  dest_reg  [NUM_SLOTS];
    logic [2:0]  dest_next [NUM_SLOTS];
    logic [9:0]  vj_reg    [NUM_SLOTS];
    logic [9:0]  vj_next   [NUM_SLOTS];
    logic [9:0]  vk_reg    [NUM_SLOTS];
    logic [9:0]  vk_next   [NUM_SLOTS];
    logic [2:0]  qj_reg    [NUM_SLOTS];
    logic [2:0]  qj_next   [NUM_SLOTS];
    logic [2:0]  qk_reg    [NUM_SLOTS];
    logic [2:0]  qk_next   [NUM_SLOTS];

    logic        disp_valid_reg, disp_valid_next;
    logic [1:0]  disp_op_reg,    disp_op_next;
    logic [9:0]  disp_vj_reg,    disp_vj_next;
    logic [9:0]  disp_vk_reg,    disp_vk_next;
    logic [1:0]  disp_slot_reg,  disp_slot_next;
    logic [2:0]  disp_dest_reg,  disp_dest_next;

    logic        cdb_valid;
    logic [1:0]  cdb_slot;
    logic [9:0]  cdb_data;

    logic [NUM_SLOTS-1:0] free_vec;
    logic [NUM_SLOTS-1:0] ready_vec;
    logic [NUM_SLOTS-1:0] snoop_j_vec;
    logic [NUM_SLOTS-1:0] snoop_k_vec;
    logic [NUM_SLOTS-1:0] retire_vec;

    logic [1:0]  free_idx;
    logic [1:0]  cand_idx;
    logic        cand_found;
    logic        issue_fire;
    logic        disp_load;
    logic        disp_take;
    logic        fwd_j;
    logic        fwd_k;
    logic [9:0]  issue_vj_eff;
    logic [9:0]  issue_vk_eff;
    logic [2:0]  issue_qj_eff;
    logic [2:0]  issue_qk_eff;

    // An all-zero bus word is the idle pattern, never a real broadcast.
    assign cdb_valid = (cdb != 16'h0000);
    assign cdb_slot  = cdb[12:11];
    assign cdb_data  = cdb[9:0];

    generate
        for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
            assign free_vec[gi]    = (state_reg[gi] == SLOT_FREE);
            assign ready_vec[gi]   = (state_reg[gi] == SLOT_WAIT) && !qj_reg[gi][2] && !qk_reg[gi][2];
            assign snoop_j_vec[gi] = cdb_valid && (state_reg[gi] == SLOT_WAIT) && qj_reg[gi][2]
                                     && (qj_reg[gi][1:0] == cdb_slot);
            assign snoop_k_vec[gi] = cdb_valid && (state_reg[gi] == SLOT_WAIT) && qk_reg[gi][2]
                                     && (qk_reg[gi][1:0] == cdb_slot);
            assign retire_vec[gi]  = cdb_valid && (state_reg[gi] == SLOT_EXEC) && (cdb_slot == 2'(gi));
            assign rs_busy[gi]     = !free_vec[gi];
        end
    endgenerate

    // Descending scans so the lowest matching index wins.
    always_comb begin
        free_idx = 2'd0;
        cand_idx = 2'd0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (free_vec[i]) free_idx = 2'(i);
            if (ready_vec[i]) cand_idx = 2'(i);
        end
    end

    assign issue_ready = |free_vec;
    assign issue_slot  = free_idx;
    assign cand_found  = |ready_vec;
    assign issue_fire  = issue_valid && issue_ready;
    assign disp_load   = !disp_valid_reg || disp_ready;
    assign disp_take   = disp_load && cand_found;

    // A tag produced on the bus in the issue cycle is captured directly.
    assign fwd_j        = issue_qj[2] && cdb_valid && (issue_qj[1:0] == cdb_slot);
    assign fwd_k        = issue_qk[2] && cdb_valid && (issue_qk[1:0] == cdb_slot);
    assign issue_vj_eff = fwd_j ? cdb_data : issue_vj;
    assign issue_vk_eff = fwd_k ? cdb_data : issue_vk;
    assign issue_qj_eff = fwd_j ? 3'b000 : issue_qj;
    assign issue_qk_eff = fwd_k ? 3'b000 : issue_qk;

    always_comb begin
        for (int i = 0; i < NUM_SLOTS; i++) begin
            state_next[i] = state_reg[i];
            op_next[i]    = op_reg[i];
            dest_next[i]  = dest_reg[i];
            vj_next[i]    = vj_reg[i];
            vk_next[i]    = vk_reg[i];
            qj_next[i]    = qj_reg[i];
            qk_next[i]    = qk_reg[i];

            if (snoop_j_vec[i]) begin
                vj_next[i] = cdb_data;
                qj_next[i] = 3'b000;
            end
            if (snoop_k_vec[i]) begin
                vk_next[i] = cdb_data;
                qk_next[i] = 3'b000;
            end
            if (retire_vec[i]) begin
                state_next[i] = SLOT_FREE;
            end
            if (disp_take && (cand_idx == 2'(i))) begin
                state_next[i] = SLOT_EXEC;
            end
            if (issue_fire && (free_idx == 2'(i))) begin
                state_next[i] = SLOT_WAIT;
                op_next[i]    = issue_op;
                dest_next[i]  = issue_dest;
                vj_next[i]    = issue_vj_eff;
                vk_next[i]    = issue_vk_eff;
                qj_next[i]    = issue_qj_eff;
                qk_next[i]    = issue_qk_eff;
            end
        end
    end

    always_comb begin
        disp_valid_next = disp_valid_reg;
        disp_op_next    = disp_op_reg;
        disp_vj_next    = disp_vj_reg;
        disp_vk_next    = disp_vk_reg;
        disp_slot_next  = disp_slot_reg;
        disp_dest_next  = disp_dest_reg;
        if (disp_load) begin
            disp_valid_next = cand_found;
            if (cand_found) begin
                disp_op_next   = op_reg[cand_idx];
                disp_vj_next   = vj_reg[cand_idx];
                disp_vk_next   = vk_reg[cand_idx];
                disp_slot_next = cand_idx;
                disp_dest_next = dest_reg[cand_idx];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_reg[i] <= SLOT_FREE;
                op_reg[i]    <= '0;
                dest_reg[i]  <= '0;
                vj_reg[i]    <= '0;
                vk_reg[i]    <= '0;
                qj_reg[i]    <= '0;
                qk_reg[i]    <= '0;
            end
            disp_valid_reg <= 1'b0;
            disp_op_reg    <= '0;
            disp_vj_reg    <= '0;
            disp_vk_reg    <= '0;
            disp_slot_reg  <= '0;
            disp_dest_reg  <= '0;
        end else begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                state_reg[i] <= state_next[i];
                op_reg[i]    <= op_next[i];
                dest_reg[i]  <= dest_next[i];
                vj_reg[i]    <= vj_next[i];
                vk_reg[i]    <= vk_next[i];
                qj_reg[i]    <= qj_next[i];
                qk_reg[i]    <= qk_next[i];
            end
            disp_valid_reg <= disp_valid_next;
            disp_op_reg    <= disp_op_next;
            disp_vj_reg    <= disp_vj_next;
            disp_vk_reg    <= disp_vk_next;
            disp_slot_reg  <= disp_slot_next;
            disp_dest_reg  <= disp_dest_next;
        end
    end

    assign disp_valid = disp_valid_reg;
    assign disp_op    = disp_op_reg;
    assign disp_vj    = disp_vj_reg;
    assign disp_vk    = disp_vk_reg;
    assign disp_slot  = disp_slot_reg;
    assign disp_dest  = disp_dest_reg;

endmodule
